// File: rtl/eth_phy_pkg.sv
// Shared constants for the MII PHY model: MDIO register defaults, frame codes, FSM states.
package eth_phy_pkg;

  localparam logic [15:0] MDIO_REG0_DEF = 16'h3100;
  localparam logic [15:0] MDIO_REG1_VAL = 16'h782D;
  localparam logic [15:0] MDIO_REG2_VAL = 16'h0013;
  localparam logic [15:0] MDIO_REG3_VAL = 16'h78E2;
  localparam logic [15:0] MDIO_REG4_DEF = 16'h01E1;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;

  localparam logic [2:0] RX_IDLE = 3'd0;
  localparam logic [2:0] RX_PRE  = 3'd1;
  localparam logic [2:0] RX_SFD  = 3'd2;
  localparam logic [2:0] RX_DATA = 3'd3;
  localparam logic [2:0] RX_END  = 3'd4;

  localparam logic [1:0] MD_HUNT = 2'd0;
  localparam logic [1:0] MD_HDR  = 2'd1;
  localparam logic [1:0] MD_RD   = 2'd2;
  localparam logic [1:0] MD_WR   = 2'd3;

endpackage

// File: rtl/eth_phy_mdio.sv
// Clause-22 MDIO management slave: mdc synchronizer, bit-serial frame FSM, register file.
module eth_phy_mdio
  import eth_phy_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'h01
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic mdc_i,
  input  logic md_i,
  output logic md_o,
  output logic md_oe_o
);

  logic [2:0]  mdc_sync_q;
  logic [1:0]  md_sync_q;
  logic        mdc_rise, mdc_fall, md_bit;
  logic [1:0]  state_q, state_d;
  logic [5:0]  ones_q, ones_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [12:0] hdr_q, hdr_d, hdr_nx;
  logic [15:0] wr_q, wr_d, wr_nx;
  logic [15:0] rd_q, rd_d, rd_val;
  logic [15:0] reg0_q, reg0_d, reg4_q, reg4_d;
  logic        md_o_q, md_o_d, md_oe_q, md_oe_d;

  // md is delayed by the same two stages as mdc so the sampled bit lines up with the edge
  assign mdc_rise = mdc_sync_q[1] & ~mdc_sync_q[2];
  assign mdc_fall = ~mdc_sync_q[1] & mdc_sync_q[2];
  assign md_bit   = md_sync_q[1];
  assign hdr_nx   = {hdr_q[11:0], md_bit};
  assign wr_nx    = {wr_q[14:0], md_bit};
  assign md_o     = md_o_q;
  assign md_oe_o  = md_oe_q;

  always_comb begin
    rd_val = 16'h0000;
    case (hdr_nx[4:0])
      5'd0:    rd_val = reg0_q;
      5'd1:    rd_val = MDIO_REG1_VAL;
      5'd2:    rd_val = MDIO_REG2_VAL;
      5'd3:    rd_val = MDIO_REG3_VAL;
      5'd4:    rd_val = reg4_q;
      default: rd_val = 16'h0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    reg0_d  = reg0_q;
    reg4_d  = reg4_q;
    md_o_d  = md_o_q;
    md_oe_d = md_oe_q;
    case (state_q)
      MD_HUNT: if (mdc_rise) begin
        if (md_bit) begin
          if (ones_q != 6'd32) ones_d = ones_q + 6'd1;
        end else if (ones_q == 6'd32) begin
          state_d = MD_HDR;
          cnt_d   = 5'd0;
        end else begin
          ones_d = 6'd0;
        end
      end
      MD_HDR: if (mdc_rise) begin
        hdr_d = hdr_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd12) begin
          state_d = MD_HUNT;
          ones_d  = 6'd0;
          cnt_d   = 5'd0;
          if (hdr_nx[12] == MDIO_ST[0] && hdr_nx[9:5] == PHY_ADDR) begin
            if (hdr_nx[11:10] == MDIO_OP_RD) begin
              state_d = MD_RD;
              rd_d    = rd_val;
            end else if (hdr_nx[11:10] == MDIO_OP_WR) begin
              state_d = MD_WR;
            end
          end
        end
      end
      // fall 0 is the first TA bit (released), fall 1 drives TA 0, falls 2..17 the data
      MD_RD: if (mdc_fall) begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd1) begin
          md_oe_d = 1'b1;
          md_o_d  = 1'b0;
        end else if (cnt_q == 5'd18) begin
          md_oe_d = 1'b0;
          md_o_d  = 1'b0;
          state_d = MD_HUNT;
          cnt_d   = 5'd0;
        end else if (cnt_q >= 5'd2) begin
          md_o_d = rd_q[15];
          rd_d   = {rd_q[14:0], 1'b0};
        end
      end
      MD_WR: if (mdc_rise) begin
        cnt_d = cnt_q + 5'd1;
        wr_d  = wr_nx;
        if (cnt_q == 5'd17) begin
          state_d = MD_HUNT;
          cnt_d   = 5'd0;
          if (hdr_q[4:0] == 5'd0) reg0_d = {1'b0, wr_nx[14:0]};
          else if (hdr_q[4:0] == 5'd4) reg4_d = wr_nx;
        end
      end
      default: state_d = MD_HUNT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mdc_sync_q <= '0;
      md_sync_q  <= '0;
      state_q    <= MD_HUNT;
      ones_q     <= '0;
      cnt_q      <= '0;
      hdr_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      reg0_q     <= MDIO_REG0_DEF;
      reg4_q     <= MDIO_REG4_DEF;
      md_o_q     <= 1'b0;
      md_oe_q    <= 1'b0;
    end else begin
      mdc_sync_q <= {mdc_sync_q[1:0], mdc_i};
      md_sync_q  <= {md_sync_q[0], md_i};
      state_q    <= state_d;
      ones_q     <= ones_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      reg0_q     <= reg0_d;
      reg4_q     <= reg4_d;
      md_o_q     <= md_o_d;
      md_oe_q    <= md_oe_d;
    end
  end

endmodule

// File: rtl/eth_phy.sv
// MII PHY model top: clock divider, RX frame playback from memory, TX frame capture, MDIO slave.
module eth_phy
  import eth_phy_pkg::*;
#(
  parameter int         CLK_DIV     = 2,
  parameter int         RX_MEM_AW   = 11,
  parameter int         TX_MEM_AW   = 11,
  parameter logic [4:0] PHY_ADDR    = 5'h01,
  parameter bit         FULL_DUPLEX = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 m_rst_n_i,
  output logic                 mtx_clk_o,
  input  logic [3:0]           mtxd_i,
  input  logic                 mtxen_i,
  input  logic                 mtxerr_i,
  output logic                 mrx_clk_o,
  output logic [3:0]           mrxd_o,
  output logic                 mrxdv_o,
  output logic                 mrxerr_o,
  output logic                 mcoll_o,
  output logic                 mcrs_o,
  input  logic                 mdc_i,
  inout  wire                  md_io,
  input  logic                 rx_mem_we_i,
  input  logic [RX_MEM_AW-1:0] rx_mem_addr_i,
  input  logic [7:0]           rx_mem_wdata_i,
  input  logic                 rx_start_i,
  input  logic [63:0]          rx_preamble_i,
  input  logic [3:0]           rx_pre_len_i,
  input  logic [7:0]           rx_sfd_i,
  input  logic [RX_MEM_AW-1:0] rx_start_addr_i,
  input  logic [15:0]          rx_len_i,
  input  logic                 rx_plus_err_i,
  output logic                 rx_busy_o,
  input  logic [TX_MEM_AW-1:0] tx_rd_addr_i,
  output logic [7:0]           tx_rd_data_o,
  output logic [15:0]          tx_len_o,
  output logic                 phy_log
);

  logic unused_txerr;
  assign unused_txerr = mtxerr_i;

  // MII clock divider
  logic [15:0] div_q, div_d;
  logic        mii_clk_q, mii_clk_d;
  logic        tick, fall_tick;

  assign tick      = (div_q == 16'(CLK_DIV - 1));
  assign fall_tick = tick & mii_clk_q;
  assign div_d     = tick ? 16'd0 : div_q + 16'd1;
  assign mii_clk_d = mii_clk_q ^ tick;
  assign mtx_clk_o = mii_clk_q;
  assign mrx_clk_o = mii_clk_q;

  // RX playback
  logic [7:0]           rx_mem [0:(1<<RX_MEM_AW)-1];
  logic [2:0]           rx_st_q, rx_st_d;
  logic [63:0]          pre_q, pre_d;
  logic [3:0]           pre_len_q, pre_len_d;
  logic [7:0]           sfd_q, sfd_d;
  logic [RX_MEM_AW-1:0] raddr_q, raddr_d;
  logic [15:0]          len_q, len_d, bcnt_q, bcnt_d;
  logic                 plus_err_q, plus_err_d, nib_hi_q, nib_hi_d;
  logic [3:0]           mrxd_q, mrxd_d;
  logic                 mrxdv_q, mrxdv_d, mrxerr_q, mrxerr_d;
  logic [5:0]           pre_idx;
  logic [7:0]           cur_byte;

  assign pre_idx = {bcnt_q[2:0], 3'b000};

  always_comb begin
    cur_byte = 8'h00;
    case (rx_st_q)
      RX_PRE:  cur_byte = pre_q[pre_idx +: 8];
      RX_SFD:  cur_byte = sfd_q;
      RX_DATA: cur_byte = rx_mem[raddr_q];
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    pre_d      = pre_q;
    pre_len_d  = pre_len_q;
    sfd_d      = sfd_q;
    raddr_d    = raddr_q;
    len_d      = len_q;
    bcnt_d     = bcnt_q;
    plus_err_d = plus_err_q;
    nib_hi_d   = nib_hi_q;
    mrxd_d     = mrxd_q;
    mrxdv_d    = mrxdv_q;
    mrxerr_d   = mrxerr_q;
    if (rx_st_q == RX_IDLE) begin
      if (rx_start_i) begin
        pre_d      = rx_preamble_i;
        pre_len_d  = (rx_pre_len_i > 4'd8) ? 4'd8 : rx_pre_len_i;
        sfd_d      = rx_sfd_i;
        raddr_d    = rx_start_addr_i;
        len_d      = rx_len_i;
        plus_err_d = rx_plus_err_i;
        bcnt_d     = 16'd0;
        nib_hi_d   = 1'b0;
        rx_st_d    = (rx_pre_len_i == 4'd0) ? RX_SFD : RX_PRE;
      end
    end else if (fall_tick) begin
      if (rx_st_q == RX_END) begin
        mrxd_d   = 4'h0;
        mrxdv_d  = 1'b0;
        mrxerr_d = 1'b0;
        rx_st_d  = RX_IDLE;
      end else begin
        mrxdv_d  = 1'b1;
        mrxd_d   = nib_hi_q ? cur_byte[7:4] : cur_byte[3:0];
        mrxerr_d = (rx_st_q == RX_DATA) && plus_err_q && (bcnt_q == len_q - 16'd1);
        nib_hi_d = ~nib_hi_q;
        if (nib_hi_q) begin
          bcnt_d = bcnt_q + 16'd1;
          case (rx_st_q)
            RX_PRE: if (bcnt_d == {12'd0, pre_len_q}) rx_st_d = RX_SFD;
            RX_SFD: begin
              bcnt_d  = 16'd0;
              rx_st_d = (len_q == 16'd0) ? RX_END : RX_DATA;
            end
            RX_DATA: begin
              raddr_d = raddr_q + 1'b1;
              if (bcnt_d == len_q) rx_st_d = RX_END;
            end
            default: rx_st_d = RX_END;
          endcase
        end
      end
    end
  end

  // TX capture
  logic [7:0]           tx_mem [0:(1<<TX_MEM_AW)-1];
  logic                 tx_nib_hi_q, tx_nib_hi_d, txen_prev_q, txen_prev_d;
  logic [3:0]           tx_lo_q, tx_lo_d;
  logic [TX_MEM_AW-1:0] tx_waddr_q, tx_waddr_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d, tx_len_q, tx_len_d;
  logic                 phy_log_q, phy_log_d, tx_we;
  logic [7:0]           tx_rd_q;

  always_comb begin
    tx_nib_hi_d = tx_nib_hi_q;
    txen_prev_d = txen_prev_q;
    tx_lo_d     = tx_lo_q;
    tx_waddr_d  = tx_waddr_q;
    tx_cnt_d    = tx_cnt_q;
    tx_len_d    = tx_len_q;
    phy_log_d   = 1'b0;
    tx_we       = 1'b0;
    if (fall_tick) begin
      txen_prev_d = mtxen_i;
      if (mtxen_i) begin
        tx_nib_hi_d = ~tx_nib_hi_q;
        if (!tx_nib_hi_q) begin
          tx_lo_d = mtxd_i;
        end else begin
          tx_we = m_rst_n_i;
          if (tx_waddr_q != '1) tx_waddr_d = tx_waddr_q + 1'b1;
          if (tx_cnt_q != 16'hFFFF) tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end else if (txen_prev_q) begin
        // end of frame; a half-collected trailing nibble is discarded here
        tx_len_d    = tx_cnt_q;
        phy_log_d   = 1'b1;
        tx_cnt_d    = 16'd0;
        tx_waddr_d  = '0;
        tx_nib_hi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_mem_we_i) rx_mem[rx_mem_addr_i] <= rx_mem_wdata_i;
    if (tx_we) tx_mem[tx_waddr_q] <= {mtxd_i, tx_lo_q};
    tx_rd_q <= tx_mem[tx_rd_addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (!m_rst_n_i) begin
      div_q       <= '0;
      mii_clk_q   <= 1'b0;
      rx_st_q     <= RX_IDLE;
      pre_q       <= '0;
      pre_len_q   <= '0;
      sfd_q       <= '0;
      raddr_q     <= '0;
      len_q       <= '0;
      bcnt_q      <= '0;
      plus_err_q  <= 1'b0;
      nib_hi_q    <= 1'b0;
      mrxd_q      <= '0;
      mrxdv_q     <= 1'b0;
      mrxerr_q    <= 1'b0;
      tx_nib_hi_q <= 1'b0;
      txen_prev_q <= 1'b0;
      tx_lo_q     <= '0;
      tx_waddr_q  <= '0;
      tx_cnt_q    <= '0;
      tx_len_q    <= '0;
      phy_log_q   <= 1'b0;
    end else begin
      div_q       <= div_d;
      mii_clk_q   <= mii_clk_d;
      rx_st_q     <= rx_st_d;
      pre_q       <= pre_d;
      pre_len_q   <= pre_len_d;
      sfd_q       <= sfd_d;
      raddr_q     <= raddr_d;
      len_q       <= len_d;
      bcnt_q      <= bcnt_d;
      plus_err_q  <= plus_err_d;
      nib_hi_q    <= nib_hi_d;
      mrxd_q      <= mrxd_d;
      mrxdv_q     <= mrxdv_d;
      mrxerr_q    <= mrxerr_d;
      tx_nib_hi_q <= tx_nib_hi_d;
      txen_prev_q <= txen_prev_d;
      tx_lo_q     <= tx_lo_d;
      tx_waddr_q  <= tx_waddr_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_len_q    <= tx_len_d;
      phy_log_q   <= phy_log_d;
    end
  end

  assign mrxd_o       = mrxd_q;
  assign mrxdv_o      = mrxdv_q;
  assign mcrs_o       = mrxdv_q;
  assign mrxerr_o     = mrxerr_q;
  assign rx_busy_o    = (rx_st_q != RX_IDLE);
  assign mcoll_o      = FULL_DUPLEX ? 1'b0 : (mtxen_i & rx_busy_o);
  assign tx_rd_data_o = tx_rd_q;
  assign tx_len_o     = tx_len_q;
  assign phy_log      = phy_log_q;

  // MDIO
  logic md_out, md_oe;

  eth_phy_mdio #(.PHY_ADDR(PHY_ADDR)) u_mdio (
    .clk_i   (clk_i),
    .rst_n_i (m_rst_n_i),
    .mdc_i   (mdc_i),
    .md_i    (md_io),
    .md_o    (md_out),
    .md_oe_o (md_oe)
  );

  assign md_io = md_oe ? md_out : 1'bz;

endmodule

// File: tb/tb_eth_phy.sv
// Directed bench for eth_phy: RX playback and TX capture scoreboards, MDIO read/write frames.
module tb_eth_phy;

  logic        clk_i = 1'b0, m_rst_n_i = 1'b0;
  logic [3:0]  mtxd_i = 4'h0;
  logic        mtxen_i = 1'b0, mtxerr_i = 1'b0;
  logic        mtx_clk_o, mrx_clk_o, mrxdv_o, mrxerr_o, mcoll_o, mcrs_o;
  logic [3:0]  mrxd_o;
  logic        mdc_i = 1'b0;
  wire         md_io;
  logic        tb_md_oe = 1'b0, tb_md_o = 1'b0;
  logic        rx_mem_we_i = 1'b0;
  logic [10:0] rx_mem_addr_i = '0;
  logic [7:0]  rx_mem_wdata_i = '0;
  logic        rx_start_i = 1'b0;
  logic [63:0] rx_preamble_i = '0;
  logic [3:0]  rx_pre_len_i = '0;
  logic [7:0]  rx_sfd_i = '0;
  logic [10:0] rx_start_addr_i = '0;
  logic [15:0] rx_len_i = '0;
  logic        rx_plus_err_i = 1'b0, rx_busy_o;
  logic [10:0] tx_rd_addr_i = '0;
  logic [7:0]  tx_rd_data_o;
  logic [15:0] tx_len_o;
  logic        phy_log;

  assign md_io = tb_md_oe ? tb_md_o : 1'bz;
  pullup (md_io);

  eth_phy dut (
    .clk_i(clk_i), .m_rst_n_i(m_rst_n_i),
    .mtx_clk_o(mtx_clk_o), .mtxd_i(mtxd_i), .mtxen_i(mtxen_i), .mtxerr_i(mtxerr_i),
    .mrx_clk_o(mrx_clk_o), .mrxd_o(mrxd_o), .mrxdv_o(mrxdv_o), .mrxerr_o(mrxerr_o),
    .mcoll_o(mcoll_o), .mcrs_o(mcrs_o), .mdc_i(mdc_i), .md_io(md_io),
    .rx_mem_we_i(rx_mem_we_i), .rx_mem_addr_i(rx_mem_addr_i), .rx_mem_wdata_i(rx_mem_wdata_i),
    .rx_start_i(rx_start_i), .rx_preamble_i(rx_preamble_i), .rx_pre_len_i(rx_pre_len_i),
    .rx_sfd_i(rx_sfd_i), .rx_start_addr_i(rx_start_addr_i), .rx_len_i(rx_len_i),
    .rx_plus_err_i(rx_plus_err_i), .rx_busy_o(rx_busy_o),
    .tx_rd_addr_i(tx_rd_addr_i), .tx_rd_data_o(tx_rd_data_o), .tx_len_o(tx_len_o),
    .phy_log(phy_log)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0, failures = 0;
  int          dv_cnt = 0, err_cnt = 0, log_cnt = 0;
  logic [4:0]  rx_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  mem_model [0:2047];
  logic [4:0]  mon_exp;
  logic        prev_rxclk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RX scoreboard: the MAC samples on mrx_clk rising
  always @(negedge clk_i) begin
    if (mrx_clk_o && !prev_rxclk && mrxdv_o) begin
      dv_cnt++;
      if (mrxerr_o) err_cnt++;
      checks++;
      assert (rx_q.size() > 0) else begin
        failures++;
        $error("FAIL rx_extra got=%h exp=none", mrxd_o);
      end
      if (rx_q.size() > 0) begin
        mon_exp = rx_q.pop_front();
        checks++;
        assert ({mrxerr_o, mrxd_o} === mon_exp && mcrs_o === 1'b1) else begin
          failures++;
          $error("FAIL rx_nibble got=%h crs=%b exp=%h", {mrxerr_o, mrxd_o}, mcrs_o, mon_exp);
        end
      end
    end
    if (phy_log) log_cnt++;
    prev_rxclk = mrx_clk_o;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic mem_wr(input logic [10:0] a, input logic [7:0] d);
    rx_mem_we_i = 1'b1; rx_mem_addr_i = a; rx_mem_wdata_i = d; mem_model[a] = d;
    @(negedge clk_i);
    rx_mem_we_i = 1'b0;
  endtask

  task automatic rx_frame(input logic [63:0] pre, input logic [3:0] pl, input logic [7:0] sfd,
                          input logic [10:0] a, input logic [15:0] len, input logic pe);
    logic [7:0]  b;
    logic [10:0] ad;
    logic        e;
    for (int i = 0; i < int'(pl); i++) begin
      b = pre[i*8 +: 8];
      rx_q.push_back({1'b0, b[3:0]}); rx_q.push_back({1'b0, b[7:4]});
    end
    rx_q.push_back({1'b0, sfd[3:0]}); rx_q.push_back({1'b0, sfd[7:4]});
    ad = a;
    for (int i = 0; i < int'(len); i++) begin
      b = mem_model[ad];
      e = pe && (i == int'(len) - 1);
      rx_q.push_back({e, b[3:0]}); rx_q.push_back({e, b[7:4]});
      ad = ad + 11'd1;
    end
    rx_preamble_i = pre; rx_pre_len_i = pl; rx_sfd_i = sfd;
    rx_start_addr_i = a; rx_len_i = len; rx_plus_err_i = pe;
    rx_start_i = 1'b1;
    @(negedge clk_i);
    rx_start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000 && rx_busy_o; i++) @(negedge clk_i);
    check(tag, 32'(rx_busy_o), 32'd0);
  endtask

  task automatic wait_txrise();
    logic p, found;
    p = mtx_clk_o; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!found) begin
        @(negedge clk_i);
        if (mtx_clk_o && !p) found = 1'b1;
        p = mtx_clk_o;
      end
    end
    if (!found) check("tx_clk_run", 32'(found), 32'd1);
  endtask

  task automatic md_bit(input logic b);
    tb_md_oe = 1'b1; tb_md_o = b;
    cyc(8); mdc_i = 1'b1; cyc(8); mdc_i = 1'b0;
  endtask

  task automatic md_rbit(output logic b);
    tb_md_oe = 1'b0;
    cyc(8); b = md_io; mdc_i = 1'b1; cyc(8); mdc_i = 1'b0;
  endtask

  task automatic md_hdr(input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra);
    for (int i = 0; i < 32; i++) md_bit(1'b1);
    md_bit(1'b0); md_bit(1'b1);
    md_bit(op[1]); md_bit(op[0]);
    for (int i = 4; i >= 0; i--) md_bit(pa[i]);
    for (int i = 4; i >= 0; i--) md_bit(ra[i]);
  endtask

  task automatic md_read(input logic [4:0] pa, input logic [4:0] ra,
                         output logic ta2, output logic [15:0] d);
    logic t1, bb;
    md_hdr(2'b10, pa, ra);
    md_rbit(t1);
    md_rbit(ta2);
    d = '0;
    for (int i = 0; i < 16; i++) begin
      md_rbit(bb);
      d = {d[14:0], bb};
    end
    md_rbit(bb);
  endtask

  task automatic md_write(input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] d);
    md_hdr(2'b01, pa, ra);
    md_bit(1'b1); md_bit(1'b0);
    for (int i = 15; i >= 0; i--) md_bit(d[i]);
    tb_md_oe = 1'b0;
    cyc(16);
  endtask

  logic        ta2;
  logic [15:0] rdat;
  logic [3:0]  tx_nibs [6];

  initial begin
    // reset
    m_rst_n_i = 1'b0;
    cyc(4);
    check("rst_mtx_clk", 32'(mtx_clk_o), 32'd0);
    check("rst_mrx_clk", 32'(mrx_clk_o), 32'd0);
    check("rst_rx_pins", 32'({mrxd_o, mrxdv_o, mrxerr_o, mcrs_o, mcoll_o}), 32'd0);
    check("rst_busy", 32'(rx_busy_o), 32'd0);
    check("rst_tx_len", 32'(tx_len_o), 32'd0);
    check("rst_phy_log", 32'(phy_log), 32'd0);
    check("rst_md_released", 32'(md_io), 32'd1);
    m_rst_n_i = 1'b1;
    cyc(2);
    md_read(5'h01, 5'd0, ta2, rdat);
    check("md_reg0_default", 32'(rdat), 32'h3100);

    // RX frame: preamble, SFD, 64 data bytes
    for (int i = 0; i < 64; i++) mem_wr(11'(i), 8'(i));
    dv_cnt = 0; err_cnt = 0;
    rx_frame(64'h0055555555555555, 4'd7, 8'hD5, 11'd0, 16'd64, 1'b0);
    check("rx1_busy_set", 32'(rx_busy_o), 32'd1);
    wait_idle("rx1_done");
    cyc(2);
    check("rx1_dv_count", 32'(dv_cnt), 32'd144);
    check("rx1_err_count", 32'(err_cnt), 32'd0);
    check("rx1_sb_empty", 32'(rx_q.size()), 32'd0);
    check("rx1_dv_low", 32'({mrxdv_o, mcrs_o, mrxd_o}), 32'd0);

    // RX with error flag, wrapping address, and a start pulse while busy
    mem_wr(11'd2046, 8'hA1);
    mem_wr(11'd2047, 8'hB2);
    dv_cnt = 0; err_cnt = 0;
    rx_frame(64'h0055555555555555, 4'd7, 8'hD5, 11'd2046, 16'd4, 1'b1);
    cyc(30);
    rx_start_addr_i = 11'd5; rx_len_i = 16'd10; rx_plus_err_i = 1'b0; rx_sfd_i = 8'h77;
    rx_start_i = 1'b1; @(negedge clk_i); rx_start_i = 1'b0;
    wait_idle("rx2_done");
    cyc(2);
    check("rx2_dv_count", 32'(dv_cnt), 32'd24);
    check("rx2_err_count", 32'(err_cnt), 32'd2);
    check("rx2_sb_empty", 32'(rx_q.size()), 32'd0);
    check("rx2_err_low", 32'(mrxerr_o), 32'd0);

    // SFD-only frame
    dv_cnt = 0;
    rx_frame(64'h0, 4'd0, 8'hD5, 11'd0, 16'd0, 1'b0);
    wait_idle("rx3_done");
    cyc(2);
    check("rx3_dv_count", 32'(dv_cnt), 32'd2);
    check("rx3_sb_empty", 32'(rx_q.size()), 32'd0);

    // TX capture
    tx_nibs[0] = 4'h5; tx_nibs[1] = 4'h5; tx_nibs[2] = 4'hD;
    tx_nibs[3] = 4'h5; tx_nibs[4] = 4'hA; tx_nibs[5] = 4'hB;
    log_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      wait_txrise();
      mtxen_i = 1'b1; mtxd_i = tx_nibs[i];
      if (i % 2 == 1) tx_q.push_back({tx_nibs[i], tx_nibs[i-1]});
    end
    check("tx_mcoll", 32'(mcoll_o), 32'd0);
    wait_txrise();
    mtxen_i = 1'b0; mtxd_i = 4'h0;
    cyc(12);
    check("tx_phy_log_once", 32'(log_cnt), 32'd1);
    check("tx_len", 32'(tx_len_o), 32'd3);
    for (int a = 0; a < 3; a++) begin
      tx_rd_addr_i = 11'(a);
      cyc(2);
      if (tx_q.size() > 0) check("tx_byte", 32'(tx_rd_data_o), 32'(tx_q.pop_front()));
    end
    check("tx_sb_empty", 32'(tx_q.size()), 32'd0);

    // MDIO reads
    md_read(5'h01, 5'd2, ta2, rdat);
    check("md_reg2_ta", 32'(ta2), 32'd0);
    check("md_reg2", 32'(rdat), 32'h0013);
    md_read(5'h01, 5'd3, ta2, rdat);
    check("md_reg3", 32'(rdat), 32'h78E2);
    md_read(5'h02, 5'd2, ta2, rdat);
    check("md_other_phy_ta", 32'(ta2), 32'd1);
    check("md_other_phy_data", 32'(rdat), 32'hFFFF);
    md_read(5'h01, 5'd4, ta2, rdat);
    check("md_reg4_default", 32'(rdat), 32'h01E1);

    // MDIO writes
    md_write(5'h01, 5'd4, 16'h1234);
    md_read(5'h01, 5'd4, ta2, rdat);
    check("md_reg4_wr", 32'(rdat), 32'h1234);
    md_write(5'h01, 5'd0, 16'h8000);
    md_read(5'h01, 5'd0, ta2, rdat);
    check("md_reg0_bit15", 32'(rdat[15]), 32'd0);
    md_write(5'h01, 5'd1, 16'h0000);
    md_read(5'h01, 5'd1, ta2, rdat);
    check("md_reg1_ro", 32'(rdat), 32'h782D);
    md_write(5'h01, 5'd9, 16'hBEEF);
    md_read(5'h01, 5'd9, ta2, rdat);
    check("md_reg9_zero", 32'(rdat), 32'h0000);

    // reset mid-frame aborts playback and restores MDIO defaults
    rx_frame(64'h0055555555555555, 4'd7, 8'hD5, 11'd0, 16'd64, 1'b0);
    cyc(40);
    m_rst_n_i = 1'b0;
    cyc(2);
    check("rst_mid_busy", 32'(rx_busy_o), 32'd0);
    check("rst_mid_pins", 32'({mrxd_o, mrxdv_o, mcrs_o, mtx_clk_o}), 32'd0);
    rx_q.delete();
    m_rst_n_i = 1'b1;
    cyc(2);
    md_read(5'h01, 5'd4, ta2, rdat);
    check("rst_reg4_default", 32'(rdat), 32'h01E1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_phy.md
Name: eth_phy

Overview:
Synthesizable MII Ethernet PHY model (simplified Intel LXT971A) for SoC-level simulation of the MAC. It generates the MII TX/RX clocks and captures frames the MAC transmits. It plays back a frame from an internal receive memory on command. It implements a Clause-22 MDIO management slave. The testbench drives it directly, and the MAC side of the SoC connects to its MII pins.

Parameters:
CLK_DIV, 2, clk_i cycles per MII clock half-period (MII clock = clk_i/(2*CLK_DIV)); must be >=1
RX_MEM_AW, 11, receive-memory address width (2048 bytes)
TX_MEM_AW, 11, transmit-capture memory address width
PHY_ADDR, 5'h01, MDIO address this PHY answers to
FULL_DUPLEX, 1, 1 = mcoll_o always 0

Ports:
clk_i  in  1  system clock; all logic on rising edge
m_rst_n_i  in  1  synchronous active-low reset
mtx_clk_o  out  1  MII transmit clock
mtxd_i  in  4  MAC transmit nibble
mtxen_i  in  1  MAC transmit enable
mtxerr_i  in  1  MAC transmit error
mrx_clk_o  out  1  MII receive clock (same phase as mtx_clk_o)
mrxd_o  out  4  receive nibble
mrxdv_o  out  1  receive data valid
mrxerr_o  out  1  receive error
mcoll_o  out  1  collision
mcrs_o  out  1  carrier sense
mdc_i  in  1  MDIO clock (asynchronous, synchronized internally)
md_io  inout  1  MDIO data, tri-stated when not driving
rx_mem_we_i  in  1  write strobe into receive memory
rx_mem_addr_i  in  RX_MEM_AW  receive memory byte address
rx_mem_wdata_i  in  8  receive memory write data
rx_start_i  in  1  one-cycle pulse: begin frame playback
rx_preamble_i  in  64  preamble bytes, byte 0 in [7:0]
rx_pre_len_i  in  4  number of preamble bytes (0-8)
rx_sfd_i  in  8  start-frame delimiter byte
rx_start_addr_i  in  RX_MEM_AW  first data byte address
rx_len_i  in  16  number of data bytes
rx_plus_err_i  in  1  assert mrxerr_o during the last data byte
rx_busy_o  out  1  playback in progress
tx_rd_addr_i  in  TX_MEM_AW  capture memory read address
tx_rd_data_o  out  8  captured byte (1-cycle read latency)
tx_len_o  out  16  byte count of the last completed TX frame
phy_log  out  1  one-cycle pulse at end of each captured TX frame

Behaviour:
- Reset (m_rst_n_i=0 at a clk_i edge):
  - MII clocks low; mrxd_o=0; mrxdv_o, mrxerr_o, mcrs_o, mcoll_o = 0.
  - rx_busy_o=0, tx_len_o=0, phy_log=0, md_io released.
  - MDIO registers return to their defaults. Memory contents are not cleared.
  - Reset mid-frame aborts the frame immediately.
- MII clock: a divider toggles both clocks every CLK_DIV clk_i cycles. "rise" and "fall" tick enables mark the edges.
- RX playback:
  - rx_start_i is ignored while busy. Otherwise latch the arguments; rx_busy_o=1 from the next cycle.
  - On each fall tick, output the next nibble, low nibble of each byte first, in order: rx_pre_len_i preamble bytes, then the SFD, then rx_len_i bytes from rx_mem starting at rx_start_addr_i. The address wraps modulo 2^RX_MEM_AW.
  - mrxdv_o=mcrs_o=1 for exactly 2*(pre_len+1+len) nibbles. If rx_plus_err_i, mrxerr_o=1 for the last 2 nibbles.
  - At the next fall tick after the last nibble, all signals drop to 0 and rx_busy_o clears.
  - len=0 sends preamble+SFD only.
  - States: IDLE, PRE, SFD, DATA, END.
- TX capture:
  - Sample mtxd_i on each fall tick while mtxen_i=1. First nibble is the low nibble. Every 2nd nibble writes a byte at an incrementing address starting at 0, saturating at the last address.
  - Capture is raw: it includes preamble and SFD. An odd trailing nibble is dropped.
  - On mtxen_i falling (sampled at a fall tick): tx_len_o = bytes written; phy_log pulses.
  - mtxerr_i is ignored.
- mcoll_o = 0 when FULL_DUPLEX. Otherwise mcoll_o = mtxen_i & rx_busy_o.
- Simultaneous mem write and playback read of the same address: playback reads the old value.
- MDIO:
  - mdc_i passes through a 2-FF synchronizer with edge detection. md_io is sampled on mdc rising and driven after mdc falling.
  - Frame: ≥32 ones preamble, ST=01, OP (10 read / 01 write), PHYAD[4:0], REGAD[4:0], TA, 16 data bits, MSB first.
  - A frame whose PHYAD≠PHY_ADDR or with bad ST/OP is ignored. The slave returns to preamble hunt.
  - Read: drive 0 in the second TA bit, then 16 data bits, then release.
  - Registers:
    - reg0 control, default 16'h3100, R/W; bit 15 self-clears.
    - reg1 status 16'h782D, read-only.
    - reg2 16'h0013, reg3 16'h78E2, read-only.
    - reg4 advertise, default 16'h01E1, R/W.
    - Others read 0; writes to them are ignored.

Decomposition:
- Package eth_phy_pkg: MDIO register defaults, ST/OP codes, RX FSM state enum.
- One sub-module, eth_phy_mdio (MDIO synchronizer, shift FSM, register file). The MII clock generator, RX playback and TX capture stay in the top.

Test Plan:
- Reset: hold m_rst_n_i=0 for 4 cycles → all MII outputs 0, rx_busy_o=0, md_io high-Z, MDIO reg0 read returns 16'h3100.
- RX frame: fill rx_mem[0..63] with 8'h00..8'h3F, then pulse start (preamble 64'h0055555555555555, pre_len 7, SFD 8'hD5, addr 0, len 64) → mrxdv_o high for 144 nibbles. Nibbles are 5 ×14, then 5,D, then 0,0,1,0,2,0…F,3. mrxerr_o stays 0.
- RX error/boundary: same frame with plus_err=1, addr=2046, len=4 → data bytes come from mem[2046],[2047],[0],[1]. mrxerr_o is high only for the final 2 nibbles. A rx_start_i pulse while busy is ignored.
- TX capture: MAC drives nibbles 5,5,D,5,A,B for 6 tx clocks → tx_len_o=3; tx_rd_data_o at addr 0..2 = 8'h55, 8'h5D, 8'hBA; phy_log pulses once.
- MDIO read: 32 ones, 0110, PHYAD=00001, REGAD=00010 → PHY drives 0 then 16'h0013. A read with PHYAD=00010 gets no response.
- MDIO write: write 16'h1234 to reg4, then read it back → 16'h1234. Write 16'h8000 to reg0 → later read shows bit 15 = 0. Write to reg1 → reg1 still 16'h782D.
